// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the shared register-file write port, with a pending-destination
// scoreboard that lets ID stall on hazards against outstanding long-latency ops.
module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 4,
  parameter int MAX_PEND   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              iss_ready,
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
  output logic              hazard1_o,
  output logic              hazard2_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o
);

  localparam int NREG  = 1 << ADDR_W;
  localparam int CNT_W = $clog2(MAX_PEND + 1);

  localparam logic [CNT_W-1:0] MAX_PEND_C   = CNT_W'(MAX_PEND);
  localparam logic [3:0]       STARVE_MAX_C = 4'(STARVE_MAX);

  localparam logic [0:0] ST_NORMAL = 1'b0;
  localparam logic [0:0] ST_BOOST  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic [NREG-1:0]   pend_q, pend_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              grant0, grant1;
  logic              iss_set, pend_clr;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;

  // Ready terms depend only on the other requester's valid, so there is no loop.
  always_comb begin
    if (state_q == ST_BOOST) begin
      req1_ready = 1'b1;
      req0_ready = !req1_valid;
    end else begin
      req0_ready = 1'b1;
      req1_ready = !req0_valid;
    end
  end

  assign grant0 = req0_valid && req0_ready;
  assign grant1 = req1_valid && req1_ready;

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves a latch.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    if (state_q == ST_NORMAL) begin
      if (req1_valid && !req1_ready) begin
        starve_d = starve_q + 4'd1;
        if (starve_q + 4'd1 == STARVE_MAX_C) begin
          state_d = ST_BOOST;
        end
      end else begin
        starve_d = '0;
      end
    end else begin
      // In BOOST req1 is either granted or has withdrawn, so BOOST never outlasts one cycle.
      state_d  = ST_NORMAL;
      starve_d = '0;
    end
  end

  assign iss_ready = !pend_q[iss_addr] && (count_q < MAX_PEND_C);
  assign iss_set   = iss_valid && iss_ready && (iss_addr != '0);
  assign pend_clr  = grant1 && pend_q[req1_addr];

  // Clear and set never target the same bit: a set to a pending address is refused.
  always_comb begin
    pend_d  = pend_q;
    count_d = count_q;
    if (pend_clr) begin
      pend_d[req1_addr] = 1'b0;
    end
    if (iss_set) begin
      pend_d[iss_addr] = 1'b1;
    end
    case ({iss_set, pend_clr})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  assign hazard1_o = (chk_addr1 != '0) && pend_q[chk_addr1];
  assign hazard2_o = (chk_addr2 != '0) && pend_q[chk_addr2];

  always_comb begin
    gnt_addr = grant0 ? req0_addr : req1_addr;
    gnt_data = grant0 ? req0_data : req1_data;
    we_d     = (grant0 || grant1) && (gnt_addr != '0);
    waddr_d  = we_d ? gnt_addr : waddr_q;
    wdata_d  = we_d ? gnt_data : wdata_q;
  end

  // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_NORMAL;
      starve_q <= '0;
      // NOTE: the pending vector is a flop array, not RAM, and must be reset so no stale hazard survives.
      pend_q   <= '0;
      count_q  <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      pend_q   <= pend_d;
      count_q  <= count_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign we_o    = we_q;
  assign waddr_o = waddr_q;
  assign wdata_o = wdata_q;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback sources. Source 0 is the in-order ALU/LSU pipeline; source 1 is the long-latency MUL/DIV unit.
- Holds a pending-destination scoreboard for long-latency ops. ID uses it to stall on RAW/WAW hazards.
- Sits between the WB stage and the register file. Its registered outputs drive the register file's write enable, write address and write data.

Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register address width (32 registers)
- STARVE_MAX, 4, consecutive req1 denials before req1 is boosted; legal range 1..15
- MAX_PEND, 4, maximum outstanding long-latency destinations; legal range 1..31

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req0_valid  in  1  pipeline writeback request
- req0_addr  in  ADDR_W  pipeline destination register
- req0_data  in  DATA_W  pipeline writeback data
- req0_ready  out  1  pipeline request accepted this cycle
- req1_valid  in  1  MUL/DIV writeback request
- req1_addr  in  ADDR_W  MUL/DIV destination register
- req1_data  in  DATA_W  MUL/DIV writeback data
- req1_ready  out  1  MUL/DIV request accepted this cycle
- iss_valid  in  1  ID issues a long-latency op; reserve its destination
- iss_addr  in  ADDR_W  destination to reserve
- iss_ready  out  1  reservation accepted
- chk_addr1  in  ADDR_W  ID source/destination query 1
- chk_addr2  in  ADDR_W  ID source/destination query 2
- hazard1_o  out  1  chk_addr1 is pending
- hazard2_o  out  1  chk_addr2 is pending
- we_o  out  1  register-file write enable
- waddr_o  out  ADDR_W  register-file write address
- wdata_o  out  DATA_W  register-file write data

Behaviour:
- Reset (asynchronous, rst=1):
  - we_o=0, waddr_o=0, wdata_o=0
  - pending vector=0, pending count=0
  - starvation counter=0, FSM=NORMAL
  - Reset asserted mid-operation discards any in-flight grant and all reservations.
- Handshake: valid/ready. A transfer occurs when valid=1 and ready=1 on a rising edge. Requesters hold valid, addr and data stable until accepted. Ready may depend combinationally on the valids.
- FSM NORMAL (req0 has priority):
  - req0_ready=1
  - req1_ready=!req0_valid
- FSM BOOST (req1 has priority):
  - req1_ready=1
  - req0_ready=!req1_valid
- Starvation counter:
  - Increments each cycle in NORMAL with req1_valid=1 and req1_ready=0.
  - Clears on any req1 grant, or when req1_valid=0.
- FSM transitions:
  - NORMAL->BOOST when the counter reaches STARVE_MAX.
  - BOOST->NORMAL after one req1 grant, or when req1_valid=0. The counter clears on this transition.
- Output register (latency exactly 1 cycle from grant):
  - On a grant with addr!=0: we_o=1, waddr_o/wdata_o take the granted request's address and data.
  - On a grant with addr==0: the request is consumed and we_o=0.
  - With no grant: we_o=0; waddr_o and wdata_o hold their previous values.
  - At most one grant per cycle.
- Scoreboard:
  - Keeps a pending bit per register plus a pending count.
  - iss_ready = !pending[iss_addr] && count<MAX_PEND. Both terms use current-cycle state.
  - iss accepted with iss_addr!=0: sets pending[iss_addr] and increments the count.
  - iss accepted with iss_addr==0: accepted, no state change.
  - req1 grant: clears pending[req1_addr] and decrements the count, if the bit was set.
  - Same-cycle iss accept and req1 clear to different addresses: both take effect and the count is unchanged.
  - Same-cycle iss and req1 clear to the same address: iss is refused, because the bit is still set this cycle.
  - req0 grants never modify the scoreboard.
- Hazard outputs (combinational):
  - hazardN_o = pending[chk_addrN]
  - hazardN_o=0 for chk_addrN==0
  - The value reflects state before this cycle's edge, with no same-cycle bypass.
- A req1 grant to a non-pending address is legal. It writes the register and leaves the count unchanged.

Test Plan:
- Reset then idle: rst=1 for 3 cycles, release, drive no requests -> we_o=0, hazard1_o=0, iss_ready=1, waddr_o=0, wdata_o=0.
- Single grant: req0 addr=5 data=0xDEADBEEF for one cycle -> req0_ready=1; next cycle we_o=1, waddr_o=5, wdata_o=0xDEADBEEF; the cycle after, we_o=0.
- Contention: req0 and req1 valid continuously, STARVE_MAX=4 -> req0 granted 4 cycles, req1 granted on cycle 5, req0 regains priority on cycle 6. we_o is never 0 during the run.
- Scoreboard reservation and release:
  - iss addr=7 accepted -> hazard1_o=1 for chk_addr1=7.
  - Second iss addr=7 -> iss_ready=0.
  - req1 addr=7 grant -> hazard1_o=0 next cycle.
  - Fill to MAX_PEND=4 with addrs 1..4 -> iss_ready=0 for addr 9.
- x0 handling: req0 addr=0 data=0x1234 -> req0_ready=1 and we_o stays 0; iss addr=0 -> accepted and hazard outputs stay 0.
- Async reset mid-operation: 3 pending entries, BOOST active, rst pulsed between clock edges -> all outputs and pending state clear immediately without a clock edge; iss_ready=1.
